// File: rtl/lfsr_pkg.sv
// Shared LFSR definitions: tap masks, XNOR next-word function and checker state encoding.
package lfsr_pkg;

    localparam int unsigned LFSR_MAX_W = 32;

    // Tap k maps to bit k-1 of the word.
    localparam logic [LFSR_MAX_W-1:0] TAPS_8  = 32'h0000_00B8;
    localparam logic [LFSR_MAX_W-1:0] TAPS_16 = 32'h0000_D008;
    localparam logic [LFSR_MAX_W-1:0] TAPS_24 = 32'h00E1_0000;
    localparam logic [LFSR_MAX_W-1:0] TAPS_32 = 32'h8020_0003;

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } chk_state_t;

    function automatic logic [LFSR_MAX_W-1:0] lfsr_taps(input int unsigned width);
        logic [LFSR_MAX_W-1:0] mask;
        case (width)
            8:       mask = TAPS_8;
            16:      mask = TAPS_16;
            24:      mask = TAPS_24;
            32:      mask = TAPS_32;
            default: mask = '0;
        endcase
        return mask;
    endfunction

    // Shift left, feeding in the XNOR of the tap bits; result is masked to width.
    function automatic logic [LFSR_MAX_W-1:0] lfsr_next(input logic [LFSR_MAX_W-1:0] w,
                                                        input int unsigned width);
        logic [LFSR_MAX_W-1:0] width_mask;
        logic                  fb;
        fb         = ~^(w & lfsr_taps(width));
        width_mask = (width >= LFSR_MAX_W) ? '1
                   : LFSR_MAX_W'((64'd1 << width) - 64'd1);
        return ((w << 1) | LFSR_MAX_W'(fb)) & width_mask;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear that takes priority ahead of a same-cycle increment.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_Clk,
    input  logic             i_Rst,
    input  logic             inc,
    input  logic             clr,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            count <= '0;
        end else if (clr) begin
            count <= {{(WIDTH-1){1'b0}}, inc};
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/lfsr_checker.sv
// Self-synchronising LFSR word checker: hunts for a consistent sequence, then checks
// each valid word against a free-running reference and counts errors.
module lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int unsigned NUM_BITS   = 8,
    parameter int unsigned LOCK_COUNT = 16,
    parameter int unsigned LOSS_COUNT = 4,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic                 i_Valid,
    input  logic [NUM_BITS-1:0]  i_Data,
    input  logic                 i_Clear,
    output logic                 o_Lock,
    output logic                 o_Err,
    output logic [CNT_WIDTH-1:0] o_Err_Count,
    output logic [CNT_WIDTH-1:0] o_Word_Count,
    output logic                 o_Err_Sticky
);

    localparam int unsigned HIT_W  = $clog2(LOCK_COUNT);
    localparam int unsigned MISS_W = $clog2(LOSS_COUNT + 1);
    localparam logic [NUM_BITS-1:0] ALL_ONES = '1;

    if (!(NUM_BITS == 8 || NUM_BITS == 16 || NUM_BITS == 24 || NUM_BITS == 32)) begin : g_bad_width
        $error("lfsr_checker: NUM_BITS must be 8, 16, 24 or 32");
    end
    if (LOCK_COUNT < 2) begin : g_bad_lock
        $error("lfsr_checker: LOCK_COUNT must be at least 2");
    end
    if (LOSS_COUNT < 1) begin : g_bad_loss
        $error("lfsr_checker: LOSS_COUNT must be at least 1");
    end

    chk_state_t          state_q;
    logic [NUM_BITS-1:0] prev_q;
    logic [NUM_BITS-1:0] ref_q;
    logic                seeded_q;
    logic [HIT_W-1:0]    hit_q;
    logic [MISS_W-1:0]   miss_q;

    logic [NUM_BITS-1:0] nxt_prev;
    logic [NUM_BITS-1:0] exp_word;
    logic                hunt_match;
    logic                word_inc;
    logic                err_inc;

    assign nxt_prev   = NUM_BITS'(lfsr_next(LFSR_MAX_W'(prev_q), NUM_BITS));
    assign exp_word   = NUM_BITS'(lfsr_next(LFSR_MAX_W'(ref_q), NUM_BITS));
    assign hunt_match = seeded_q && (i_Data == nxt_prev) && (i_Data != ALL_ONES);
    assign word_inc   = i_Valid && (state_q == LOCKED);
    assign err_inc    = word_inc && (i_Data != exp_word);

    // Lock/hunt control, reference tracking and the sticky error flag.
    always_ff @(posedge i_Clk or posedge i_Rst) begin
        if (i_Rst) begin
            state_q      <= HUNT;
            prev_q       <= '0;
            ref_q        <= '0;
            seeded_q     <= 1'b0;
            hit_q        <= '0;
            miss_q       <= '0;
            o_Lock       <= 1'b0;
            o_Err        <= 1'b0;
            o_Err_Sticky <= 1'b0;
        end else begin
            o_Err        <= 1'b0;
            o_Err_Sticky <= (o_Err_Sticky & ~i_Clear) | err_inc;
            if (i_Valid) begin
                case (state_q)
                    HUNT: begin
                        prev_q   <= i_Data;
                        seeded_q <= 1'b1;
                        if (!hunt_match) begin
                            hit_q <= '0;
                        end else if (hit_q == HIT_W'(LOCK_COUNT - 2)) begin
                            state_q <= LOCKED;
                            ref_q   <= i_Data;
                            o_Lock  <= 1'b1;
                            hit_q   <= '0;
                            miss_q  <= '0;
                        end else begin
                            hit_q <= hit_q + HIT_W'(1);
                        end
                    end
                    LOCKED: begin
                        ref_q <= exp_word;
                        if (!err_inc) begin
                            miss_q <= '0;
                        end else begin
                            o_Err <= 1'b1;
                            if (miss_q == MISS_W'(LOSS_COUNT - 1)) begin
                                // The word that drops lock becomes the new hunt seed.
                                state_q  <= HUNT;
                                o_Lock   <= 1'b0;
                                hit_q    <= '0;
                                miss_q   <= '0;
                                prev_q   <= i_Data;
                                seeded_q <= 1'b1;
                            end else begin
                                miss_q <= miss_q + MISS_W'(1);
                            end
                        end
                    end
                    default: state_q <= HUNT;
                endcase
            end
        end
    end

    sat_counter #(.WIDTH(CNT_WIDTH)) u_err_cnt (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .inc   (err_inc),
        .clr   (i_Clear),
        .count (o_Err_Count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_word_cnt (
        .i_Clk (i_Clk),
        .i_Rst (i_Rst),
        .inc   (word_inc),
        .clr   (i_Clear),
        .count (o_Word_Count)
    );

endmodule

// File: doc/lfsr_checker.md
Name: lfsr_checker

Overview:
- Downstream consumer of the LFSR pattern generator. Receives the generator's parallel NUM_BITS-wide word stream, one word per valid strobe, across an HDMI/link test path.
- Locks onto the pseudo-random sequence by self-synchronisation, then checks every subsequent word against an internally predicted reference.
- Reports lock status, per-word error pulses, and saturating error/word counters for link bring-up and BER measurement.

Parameters:
- NUM_BITS, 8, word/LFSR width. Supported values: 8, 16, 24, 32; any other value is a compile-time error.
- LOCK_COUNT, 16, consecutive self-consistent words required to declare lock (>=2).
- LOSS_COUNT, 4, consecutive mismatched words while locked that force loss of lock (>=1).
- CNT_WIDTH, 16, width of the error and word counters.

Ports:
- i_Clk  in  1  system clock
- i_Rst  in  1  reset
- i_Valid  in  1  i_Data carries a word this cycle
- i_Data  in  NUM_BITS  received LFSR word
- i_Clear  in  1  synchronous clear of both counters and the sticky flag
- o_Lock  out  1  checker locked to the sequence
- o_Err  out  1  one-cycle pulse: last valid word mismatched while locked
- o_Err_Count  out  CNT_WIDTH  saturating count of mismatched words while locked
- o_Word_Count  out  CNT_WIDTH  saturating count of words checked while locked
- o_Err_Sticky  out  1  set on any error since reset/clear

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (i_Rst). It forces state HUNT, o_Lock=0, o_Err=0, both counters=0, o_Err_Sticky=0, reference=0, match counters=0.
- Next-word function nxt(w):
  - fb = XNOR chain of the tap bits (tap k = w[k-1]).
  - Taps are 8:{8,6,5,4}, 16:{16,15,13,4}, 24:{24,23,22,17}, 32:{32,22,2,1}.
  - nxt(w) = {w[NUM_BITS-2:0], fb}.
  - The all-ones word is the XNOR lock-up state.
- Cycles without i_Valid change nothing, except an i_Clear that is asserted.
- All outputs are registered and reflect a valid word one cycle after it is sampled.
- HUNT state:
  - Holds prev (last valid word) and a hit counter.
  - On a valid word d: if d == nxt(prev) and d != all-ones, hit increments; otherwise hit resets to 0. In either case prev <= d.
  - When hit reaches LOCK_COUNT-1 on a valid word, go to LOCKED the next cycle with ref <= d and o_Lock=1. Lock therefore needs LOCK_COUNT words in total, the first being the seed.
  - The first valid word after reset or after loss of lock only seeds prev.
  - No counter updates and no o_Err in HUNT.
- LOCKED state:
  - On a valid word d, exp = nxt(ref) and ref <= exp. The reference free-runs and is never re-seeded from data, so bit errors do not propagate.
  - Word count increments.
  - If d != exp: o_Err pulses, error count increments, sticky is set, and the miss counter increments. Otherwise the miss counter clears.
  - When the miss counter reaches LOSS_COUNT: go to HUNT the next cycle with o_Lock=0, hit=0, prev <= d. The counters and sticky flag retain their values.
- Counters saturate at all-ones and never wrap.
- i_Clear sets both counters and sticky to 0. If it coincides with a counted word, the clear applies first, then the increment, giving a result of 1. Clear does not affect state, lock, ref or o_Err.
- Reset during LOCKED drops o_Lock asynchronously and returns to HUNT.

Decomposition:
- Shared package lfsr_pkg holds:
  - the tap table constants per supported width;
  - a function lfsr_next(w) implementing nxt(), also usable by the generator and the bench model;
  - state enum HUNT/LOCKED.
- No sub-module is needed; a small saturating-counter sub-module sat_counter (parameter WIDTH, with inc/clr inputs) is natural and instantiated twice.

Test Plan:
- Lock acquisition (NUM_BITS=8, LOCK_COUNT=16): valid words 0x00,0x01,0x03,0x07,... (generator seeded 0x00), one per cycle -> o_Lock rises the cycle after the 16th word; counters stay 0 until then.
- Single bit error: once locked, send 20 words with word 5 XORed by 0x10 -> exactly one o_Err pulse, o_Err_Count=1, o_Word_Count=20, o_Lock stays 1, and the following word is checked as correct.
- Loss of lock (LOSS_COUNT=4): once locked, send 4 consecutive corrupted words -> 4 o_Err pulses, o_Lock falls the cycle after the 4th; then a clean stream relocks after 16 more words with o_Err_Count still 4.
- Stuck bus: 40 words of 0xFF -> o_Lock never asserts and o_Err never pulses.
- Gapped valid plus clear: i_Valid toggling 1/0 while locked, with i_Clear coinciding with a mismatched word -> no false errors across gaps; the cycle after, o_Err_Count=1, o_Word_Count=1, o_Err_Sticky=1.
- Reset mid-lock: assert i_Rst asynchronously between clock edges while locked -> o_Lock, counters and sticky go to 0 immediately; relock needs the full 16 words.
